// File: rtl/countdown_pkg.sv
// Shared types for the countdown timer: the four-state control FSM encoding.
package countdown_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      RUN    = 2'd2,
      PAUSED = 2'd3
   } state_t;

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler for the countdown timer: raises tick once every PRESCALE enabled
// cycles. The phase holds while en is low, so a paused run resumes mid-period.
// With PRESCALE = 1 there is no state and tick simply follows en.
module tick_gen #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   generate
      if (PRESCALE <= 1) begin : g_bypass
         logic unused_inputs;
         assign unused_inputs = ^{clk, rst, clr};
         assign tick = en;
      end else begin : g_div
         localparam int PW = $clog2(PRESCALE);
         localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

         logic [PW-1:0] phase;

         // Phase counter: cleared on request, advances only while enabled.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               phase <= '0;
            end else if (clr) begin
               phase <= '0;
            end else if (en) begin
               phase <= (phase == LAST) ? '0 : phase + 1'b1;
            end
         end

         assign tick = en && (phase == LAST);
      end
   endgenerate

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer. A reload value is taken over a valid/ready
// port, counting starts on command, one decrement per prescaled tick, and a
// one-cycle done pulse marks expiry (optionally reloading for periodic use).
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] reload_reg;
   logic             load_fire;
   logic             counting;
   logic             active;
   logic             tick;
   logic             terminal;
   logic             start_zero;
   logic             clr;

   // Abort outranks everything, so a load offered alongside it is refused.
   assign load_fire  = load_valid && load_ready && !abort;
   assign counting   = (state == RUN) || (state == PAUSED);
   // A PAUSED cycle with pause already released counts as a running cycle,
   // so each cycle with pause high costs exactly one cycle of delay.
   assign active     = counting && !pause && !abort;
   assign terminal   = tick && (count == WIDTH'(1));
   // Starting from a zero load expires immediately without counting.
   assign start_zero = (state == ARMED) && start && !load_fire && !abort &&
                       (count == '0);
   // Prescaler is held at zero whenever no run is in progress.
   assign clr        = abort || !counting;

   tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .en   (active),
      .tick (tick)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: abort first, then load, start, pause and expiry.
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (load_fire) state_nxt = ARMED;
            end
            ARMED: begin
               if (load_fire) begin
                  state_nxt = ARMED;
               end else if (start) begin
                  state_nxt = (count == '0) ? IDLE : RUN;
               end
            end
            RUN, PAUSED: begin
               if (pause) begin
                  state_nxt = PAUSED;
               end else if (terminal && !auto_reload) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = RUN;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Status outputs decoded from the state register.
   always_comb begin
      load_ready = (state == IDLE) || (state == ARMED);
      busy       = counting;
   end

   // Count and reload value: load, decrement, reload or clear on expiry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= '0;
         reload_reg <= '0;
      end else if (abort) begin
         count <= '0;
      end else if (load_fire) begin
         count      <= load_val;
         reload_reg <= load_val;
      end else if (terminal) begin
         count <= auto_reload ? reload_reg : '0;
      end else if (tick) begin
         count <= count - 1'b1;
      end
   end

   // One-cycle expiry pulse; abort in the same cycle suppresses it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done <= 1'b0;
      end else begin
         done <= !abort && (start_zero || terminal);
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (PRESCALE 1 and 4) share stimulus
// and are compared every cycle against a timing model that tracks elapsed
// unpaused run cycles, plus directed checks of the key scenarios.
module tb_countdown_timer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         lv;
   logic [W-1:0] lval;
   logic         st;
   logic         pz;
   logic         ab;
   logic         ar;
   logic         rdy1, rdy4;
   logic [W-1:0] cnt1, cnt4;
   logic         busy1, busy4;
   logic         done1, done4;

   int n_cmp = 0;
   int n_bad = 0;

   // mode: 0 idle, 1 loaded and waiting, 2 running (paused or not)
   typedef struct {
      int mode;
      int cnt;
      int rel;
      int act;
      bit done;
   } mdl_t;

   mdl_t m1, m4;

   always #5 clk = ~clk;

   countdown_timer #(.WIDTH(W), .PRESCALE(1)) u_p1 (
      .clk(clk), .rst(rst), .load_valid(lv), .load_ready(rdy1),
      .load_val(lval), .start(st), .pause(pz), .abort(ab),
      .auto_reload(ar), .count(cnt1), .busy(busy1), .done(done1)
   );

   countdown_timer #(.WIDTH(W), .PRESCALE(4)) u_p4 (
      .clk(clk), .rst(rst), .load_valid(lv), .load_ready(rdy4),
      .load_val(lval), .start(st), .pause(pz), .abort(ab),
      .auto_reload(ar), .count(cnt4), .busy(busy4), .done(done4)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic mdl_t mdl_clear();
      mdl_t m;
      m.mode = 0; m.cnt = 0; m.rel = 0; m.act = 0; m.done = 1'b0;
      return m;
   endfunction

   // Count value is the loaded N minus the number of whole prescale periods
   // of unpaused running time; expiry lands at N*P running cycles.
   function automatic mdl_t step(input mdl_t mi, input int p);
      mdl_t m = mi;
      m.done = 1'b0;
      if (ab) begin
         m.mode = 0; m.cnt = 0; m.act = 0;
      end else if (m.mode != 2) begin
         if (lv) begin
            m.rel = int'(lval); m.cnt = int'(lval); m.mode = 1; m.act = 0;
         end else if (m.mode == 1 && st) begin
            if (m.rel == 0) begin
               m.done = 1'b1; m.mode = 0;
            end else begin
               m.mode = 2; m.act = 0;
            end
         end
      end else if (!pz) begin
         m.act++;
         if (m.act == m.rel * p) begin
            m.done = 1'b1;
            m.act  = 0;
            if (ar) m.cnt = m.rel;
            else begin
               m.cnt = 0; m.mode = 0;
            end
         end else begin
            m.cnt = m.rel - m.act / p;
         end
      end
      return m;
   endfunction

   task automatic check_all();
      chk("p1_count", 32'(cnt1), 32'(m1.cnt));
      chk("p1_done",  32'(done1), 32'(m1.done));
      chk("p1_busy",  32'(busy1), 32'(m1.mode == 2));
      chk("p1_ready", 32'(rdy1),  32'(m1.mode != 2));
      chk("p4_count", 32'(cnt4), 32'(m4.cnt));
      chk("p4_done",  32'(done4), 32'(m4.done));
      chk("p4_busy",  32'(busy4), 32'(m4.mode == 2));
      chk("p4_ready", 32'(rdy4),  32'(m4.mode != 2));
   endtask

   task automatic cycle();
      @(posedge clk);
      m1 = step(m1, 1);
      m4 = step(m4, 4);
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      lv = 1'b0; lval = '0; st = 1'b0; pz = 1'b0; ab = 1'b0; ar = 1'b0;
   endtask

   task automatic load_start(input int n);
      lv = 1'b1; lval = W'(n);
      cycle();
      lv = 1'b0; st = 1'b1;
      cycle();
      st = 1'b0;
   endtask

   task automatic do_abort();
      ab = 1'b1;
      cycle();
      ab = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      m1 = mdl_clear();
      m4 = mdl_clear();
      #12;
      chk("rst_count", 32'(cnt1), 0);
      chk("rst_done",  32'(done1), 0);
      chk("rst_busy",  32'(busy1), 0);
      chk("rst_ready", 32'(rdy1), 1);
      chk("rst_count4", 32'(cnt4), 0);
      @(negedge clk);
      rst = 1'b0;

      // Load 3 and start: 3,2,1,0 with done on the third cycle.
      load_start(3);
      chk("t1_start_cnt", 32'(cnt1), 3);
      for (int k = 1; k <= 3; k++) begin
         cycle();
         chk("t1_cnt", 32'(cnt1), 32'(3 - k));
         chk("t1_done", 32'(done1), 32'(k == 3));
      end
      chk("t1_ready_end", 32'(rdy1), 1);
      do_abort();

      // Auto-reload with N=2: period of two cycles, busy held.
      ar = 1'b1;
      load_start(2);
      for (int k = 1; k <= 10; k++) begin
         cycle();
         chk("t2_cnt", 32'(cnt1), (k % 2 == 1) ? 1 : 2);
         chk("t2_done", 32'(done1), 32'(k % 2 == 0));
         chk("t2_busy", 32'(busy1), 1);
      end
      ar = 1'b0;
      do_abort();

      // PRESCALE=4, N=2: expiry 8 cycles after start.
      load_start(2);
      for (int k = 1; k <= 9; k++) begin
         cycle();
         chk("t3_done", 32'(done4), 32'(k == 8));
      end
      // Same again with a 3-cycle pause: expiry moves to 11.
      load_start(2);
      for (int k = 1; k <= 12; k++) begin
         pz = (k >= 4 && k <= 6);
         cycle();
         if (k >= 4 && k <= 6) chk("t3_hold", 32'(cnt4), 2);
         chk("t3p_done", 32'(done4), 32'(k == 11));
      end
      pz = 1'b0;
      do_abort();

      // Zero load: immediate done, back to idle.
      load_start(0);
      chk("t4_done0", 32'(done1), 1);
      chk("t4_cnt0", 32'(cnt1), 0);
      chk("t4_ready0", 32'(rdy1), 1);
      // Load refused while running.
      load_start(5);
      lv = 1'b1; lval = 8'd9;
      chk("t4_ready_run", 32'(rdy4), 0);
      cycle();
      lv = 1'b0;
      chk("t4_cnt_kept", 32'(cnt4), 5);
      do_abort();

      // Abort on the terminal tick suppresses done; start from IDLE ignored.
      load_start(1);
      ab = 1'b1;
      cycle();
      ab = 1'b0;
      chk("t5_done", 32'(done1), 0);
      chk("t5_cnt", 32'(cnt1), 0);
      st = 1'b1;
      cycle();
      st = 1'b0;
      chk("t5_busy", 32'(busy1), 0);
      cycle();

      // Asynchronous reset mid-count.
      load_start(9);
      for (int k = 0; k < 4; k++) cycle();
      chk("t6_pre", 32'(cnt1), 5);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_cnt", 32'(cnt1), 0);
      chk("t6_busy", 32'(busy1), 0);
      chk("t6_done", 32'(done1), 0);
      m1 = mdl_clear();
      m4 = mdl_clear();
      @(negedge clk);
      rst = 1'b0;
      cycle();

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         ab   = ($urandom_range(99) < 3);
         lv   = ($urandom_range(99) < 20);
         lval = W'($urandom_range(6));
         st   = ($urandom_range(99) < 25);
         pz   = ($urandom_range(99) < 15);
         if ($urandom_range(99) < 5) ar = ~ar;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counting timer: the countdown counterpart to the team's loadable up-counter. A reload value is accepted over a valid/ready load port, and counting starts on command. The counter decrements once per prescaled tick and emits a one-cycle `done` pulse on expiry, with optional auto-reload for periodic operation. It is intended as the timeout/period generator next to the counter in the lab datapath.

## Interface
- `WIDTH`, 8: width of the count and reload value.
- `PRESCALE`, 1: clock cycles per decrement tick; must be ≥ 1, and 1 means every cycle.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `load_valid`  in  1  reload value offered.
- `load_ready`  out  1  block can accept a load.
- `load_val`  in  WIDTH  reload value.
- `start`  in  1  begin counting from the loaded value.
- `pause`  in  1  level; freezes counting while high.
- `abort`  in  1  return to IDLE from any state.
- `auto_reload`  in  1  reload and continue on expiry.
- `count`  out  WIDTH  current count value.
- `busy`  out  1  state is RUN or PAUSED.
- `done`  out  1  one-cycle expiry pulse.

## Operation
States:
- IDLE: no value loaded, or previous run finished.
- ARMED: value loaded, waiting for `start`.
- RUN: counting.
- PAUSED: counting frozen.

Rules:
- `load_ready` is high in IDLE and ARMED and low in RUN and PAUSED. It is combinational from state.
- Load handshake: when `load_valid && load_ready`, `reload_reg <= load_val` and `count <= load_val`, and the next state is ARMED. Reloading while ARMED overwrites the value.
- ARMED with `start` and `count != 0`: go to RUN and clear the prescaler.
- ARMED with `start` and `count == 0`: `done` pulses next cycle, then IDLE. No counting occurs.
- `start` in IDLE, RUN or PAUSED is ignored.
- Tick: in RUN, the prescaler counts 0..PRESCALE-1. A tick occurs in the cycle the prescaler equals PRESCALE-1, and the prescaler then wraps to 0.
- Tick with `count > 1`: `count <= count - 1`.
- Terminal tick (`count == 1`):
  - `done <= 1`.
  - If `auto_reload` is high (sampled at the terminal tick): `count <= reload_reg` and stay in RUN.
  - Otherwise: `count <= 0` and go to IDLE.
- Pause:
  - RUN with `pause` high: go to PAUSED. The same edge does not tick, and `count` and the prescaler hold.
  - PAUSED with `pause` low: return to RUN, resuming the prescaler where it left off.
- Abort: go to IDLE from any state, with `count <= 0`, prescaler cleared and `done <= 0`. `reload_reg` is retained.
- Priority, highest first: `rst`, `abort`, `pause`, tick.
  - `abort` on a terminal-tick cycle suppresses `done`.
  - `pause` on a terminal-tick cycle defers expiry.
- Arithmetic: `count` never underflows. The 0 → all-ones transition is unreachable.

## Timing
- Reset values:
  - state IDLE, `count` 0, `reload_reg` 0, prescaler 0.
  - `done` 0, `busy` 0, `load_ready` 1.
- All outputs except `load_ready` are registered.
- Latency, PRESCALE=1, load N at edge 0, `start` sampled at edge 1:
  - `count` is N after edge 1, then N-1, …, 1.
  - After edge 1+N, `count` is 0 (or N with auto-reload) and `done` is high for exactly one cycle.
- General expiry: N·PRESCALE cycles after the start edge, plus one cycle per paused cycle.
- Auto-reload period: exactly N·PRESCALE cycles between `done` pulses.
- `done` is never high for two consecutive cycles, except when N·PRESCALE = 1 with auto-reload, where it pulses every cycle.
- `rst` asserted mid-run: outputs return to reset values immediately (asynchronously), with no `done`.

## Structure
- Package `countdown_pkg`: `state_t` enum (IDLE, ARMED, RUN, PAUSED).
- Sub-module `tick_gen`: prescaler, parameterised by PRESCALE, with inputs `clr` and `en` and output `tick`. It degenerates to `tick = en` when PRESCALE = 1.
- Top level holds the FSM, `count` and `reload_reg`.

## Test plan
- Reset then load 3, start, PRESCALE=1: `count` runs 3,2,1,0; `done` is high for one cycle exactly 3 cycles after the start edge; end state IDLE, `load_ready` 1.
- Load 2, start, `auto_reload` held high: `count` runs 2,1,2,1,…; `done` pulses every 2 cycles; `busy` stays 1.
- PRESCALE=4, load 2, start: `done` 8 cycles after start. A 3-cycle `pause` mid-run delays `done` to 11 cycles, and `count` holds during the pause.
- Load 0, start: `done` pulses the next cycle, `count` stays 0, state returns to IDLE. Load attempted during RUN: `load_ready` is 0 and the value is unchanged.
- `abort` on the terminal-tick cycle: no `done`, `count` 0, IDLE. A subsequent start from IDLE is ignored until a new load.
- Assert `rst` asynchronously mid-count (e.g. at `count` 5): `count` 0 and `busy` 0 before the next clock edge, and no `done`.
